// File: rtl/axi_read_bridge_if.sv
// AXI4 read-only bus (AR + R channels) shared by the fetch/load bridge and its slave.
interface axi_read_bridge_if;
  logic [3:0]  ARID;
  logic [63:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPORT;
  logic [3:0]  ARQOS;
  logic [3:0]  ARREGION;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPORT,
           ARQOS, ARREGION, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPORT,
           ARQOS, ARREGION, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_bridge.sv
// Single-beat AXI read bridge alternating instruction fetches and data loads.
// A load is only issued when requested at the handshake that completes a fetch.
module axi_read_bridge (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [63:0]             pc,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  input  logic [63:0]             mm_addr,
  input  logic                    mm_ren,
  output logic [63:0]             mm_rdata,
  output logic                    rdata_valid,
  input  logic                    jump_en,
  output logic                    flush_nop,
  axi_read_bridge_if.master       axi
);

  typedef enum logic [2:0] {S_RESET, S_F_AR, S_F_R, S_D_AR, S_D_R} state_t;

  state_t      state_q, state_d;
  logic [63:0] araddr_q, araddr_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] mm_rdata_q, mm_rdata_d;
  logic        instr_valid_q, instr_valid_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        unused_ok;

  assign flush_nop    = jump_en;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign mm_rdata     = mm_rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign unused_ok    = ^{axi.RID, axi.RRESP, axi.RLAST};

  assign axi.ARADDR   = araddr_q;
  assign axi.ARLEN    = 8'd0;
  assign axi.ARBURST  = 2'b01;
  assign axi.ARLOCK   = 1'b0;
  assign axi.ARCACHE  = 4'd0;
  assign axi.ARQOS    = 4'd0;
  assign axi.ARREGION = 4'd0;

  // AR attributes come from the state alone, so they stay stable during a stall.
  always_comb begin
    axi.ARVALID = 1'b0;
    axi.ARID    = 4'd0;
    axi.ARSIZE  = 3'b000;
    axi.ARPORT  = 3'b000;
    axi.RREADY  = 1'b0;
    case (state_q)
      S_F_AR: begin
        axi.ARVALID = 1'b1;
        axi.ARSIZE  = 3'b010;
        axi.ARPORT  = 3'b100;
      end
      S_D_AR: begin
        axi.ARVALID = 1'b1;
        axi.ARID    = 4'd1;
        axi.ARSIZE  = 3'b011;
      end
      S_F_R, S_D_R: axi.RREADY = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    araddr_d      = araddr_q;
    instr_d       = instr_q;
    mm_rdata_d    = mm_rdata_q;
    instr_valid_d = 1'b0;
    rdata_valid_d = 1'b0;
    case (state_q)
      S_RESET: begin
        state_d  = S_F_AR;
        araddr_d = pc;
      end
      S_F_AR: if (axi.ARREADY) state_d = S_F_R;
      S_F_R: if (axi.RVALID) begin
        // araddr_q still holds the fetch address here and selects the word.
        instr_d       = araddr_q[2] ? axi.RDATA[63:32] : axi.RDATA[31:0];
        instr_valid_d = 1'b1;
        if (mm_ren) begin
          state_d  = S_D_AR;
          araddr_d = mm_addr;
        end else begin
          state_d  = S_F_AR;
          araddr_d = pc;
        end
      end
      S_D_AR: if (axi.ARREADY) state_d = S_D_R;
      S_D_R: if (axi.RVALID) begin
        mm_rdata_d    = axi.RDATA;
        rdata_valid_d = 1'b1;
        state_d       = S_F_AR;
        araddr_d      = pc;
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q       <= S_RESET;
      araddr_q      <= 64'd0;
      instr_q       <= 32'd0;
      mm_rdata_q    <= 64'd0;
      instr_valid_q <= 1'b0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      araddr_q      <= araddr_d;
      instr_q       <= instr_d;
      mm_rdata_q    <= mm_rdata_d;
      instr_valid_q <= instr_valid_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

endmodule

// File: tb/tb_axi_read_bridge.sv
// Directed bench for axi_read_bridge: fetch word select, fetch->load hand-off,
// AR stall hold, flush pass-through and asynchronous mid-transaction reset.
module tb_axi_read_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [63:0] mm_addr;
  logic        mm_ren;
  logic [63:0] mm_rdata;
  logic        rdata_valid;
  logic        jump_en;
  logic        flush_nop;
  int          total = 0;
  int          bad   = 0;

  localparam logic [63:0] RD1 = 64'h0000_0013_0010_0073;
  localparam logic [63:0] RD2 = 64'h1122_3344_5566_7788;

  axi_read_bridge_if bus ();

  axi_read_bridge dut (
    .clk         (clk),
    .rstn        (rstn),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .mm_addr     (mm_addr),
    .mm_ren      (mm_ren),
    .mm_rdata    (mm_rdata),
    .rdata_valid (rdata_valid),
    .jump_en     (jump_en),
    .flush_nop   (flush_nop),
    .axi         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] pcV, input logic [63:0] addrV, input logic renV,
                               input logic arreadyV, input logic rvalidV, input logic [63:0] rdataV);
    pc          = pcV;
    mm_addr     = addrV;
    mm_ren      = renV;
    bus.ARREADY = arreadyV;
    bus.RVALID  = rvalidV;
    bus.RDATA   = rdataV;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_arvalid"}, 64'(bus.ARVALID), 64'd0);
    checkOutput({tag, "_rready"}, 64'(bus.RREADY), 64'd0);
    checkOutput({tag, "_araddr"}, bus.ARADDR, 64'd0);
    checkOutput({tag, "_arid"}, 64'(bus.ARID), 64'd0);
    checkOutput({tag, "_instr"}, 64'(instr), 64'd0);
    checkOutput({tag, "_mm_rdata"}, mm_rdata, 64'd0);
    checkOutput({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
    checkOutput({tag, "_rdata_valid"}, 64'(rdata_valid), 64'd0);
  endtask

  initial begin
    rstn      = 1'b1;
    jump_en   = 1'b0;
    bus.RID   = 4'd0;
    bus.RRESP = 2'b00;
    bus.RLAST = 1'b1;
    applyStimulus(64'h8000_0000, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    repeat (2) @(negedge clk);
    checkResetValues("rst");

    // Release reset; first edge enters F_AR latching pc.
    rstn = 1'b0;
    applyStimulus(64'h8000_0000, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0);
    @(negedge clk);
    checkOutput("far_arvalid", 64'(bus.ARVALID), 64'd1);
    checkOutput("far_araddr", bus.ARADDR, 64'h8000_0000);
    checkOutput("far_arid", 64'(bus.ARID), 64'd0);
    checkOutput("far_arsize", 64'(bus.ARSIZE), 64'd2);
    checkOutput("far_arport", 64'(bus.ARPORT), 64'd4);
    checkOutput("far_arlen", 64'(bus.ARLEN), 64'd0);
    checkOutput("far_arburst", 64'(bus.ARBURST), 64'd1);
    checkOutput("far_rready", 64'(bus.RREADY), 64'd0);
    applyStimulus(64'h8000_0000, 64'd0, 1'b0, 1'b1, 1'b1, RD1);

    @(negedge clk);
    checkOutput("fr_rready", 64'(bus.RREADY), 64'd1);
    checkOutput("fr_arvalid", 64'(bus.ARVALID), 64'd0);
    checkOutput("fr_instr_valid", 64'(instr_valid), 64'd0);
    applyStimulus(64'h8000_0004, 64'd0, 1'b0, 1'b1, 1'b1, RD1);

    @(negedge clk);
    checkOutput("f1_instr", 64'(instr), 64'h0010_0073);
    checkOutput("f1_instr_valid", 64'(instr_valid), 64'd1);
    checkOutput("f1_rdata_valid", 64'(rdata_valid), 64'd0);
    checkOutput("f2_araddr", bus.ARADDR, 64'h8000_0004);

    @(negedge clk);
    checkOutput("f1_pulse_end", 64'(instr_valid), 64'd0);
    checkOutput("f1_instr_hold", 64'(instr), 64'h0010_0073);

    @(negedge clk);
    checkOutput("f2_instr", 64'(instr), 64'h0000_0013);
    checkOutput("f2_instr_valid", 64'(instr_valid), 64'd1);
    // mm_ren raised while in F_AR must not divert this fetch.
    applyStimulus(64'h8000_0004, 64'h8000_1000, 1'b1, 1'b1, 1'b1, RD2);

    @(negedge clk);
    checkOutput("f3_in_fr_arvalid", 64'(bus.ARVALID), 64'd0);
    checkOutput("f3_in_fr_rready", 64'(bus.RREADY), 64'd1);

    @(negedge clk);
    checkOutput("f3_instr", 64'(instr), 64'h1122_3344);
    checkOutput("dar_arvalid", 64'(bus.ARVALID), 64'd1);
    checkOutput("dar_arid", 64'(bus.ARID), 64'd1);
    checkOutput("dar_arsize", 64'(bus.ARSIZE), 64'd3);
    checkOutput("dar_arport", 64'(bus.ARPORT), 64'd0);
    checkOutput("dar_araddr", bus.ARADDR, 64'h8000_1000);
    applyStimulus(64'h8000_0008, 64'h8000_1000, 1'b0, 1'b1, 1'b1, RD2);
    bus.RRESP = 2'b10;
    bus.RID   = 4'd5;

    @(negedge clk);
    checkOutput("dr_rready", 64'(bus.RREADY), 64'd1);
    checkOutput("dr_instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("dr_rdata_valid", 64'(rdata_valid), 64'd0);

    @(negedge clk);
    checkOutput("ld_mm_rdata", mm_rdata, RD2);
    checkOutput("ld_rdata_valid", 64'(rdata_valid), 64'd1);
    checkOutput("ld_instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("ld_next_fetch_arid", 64'(bus.ARID), 64'd0);
    checkOutput("ld_next_fetch_araddr", bus.ARADDR, 64'h8000_0008);
    applyStimulus(64'h8000_0010, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    bus.RRESP = 2'b00;

    // Five stalled AR cycles while pc keeps moving; jump_en pulses meanwhile.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_arvalid", 64'(bus.ARVALID), 64'd1);
      checkOutput("stall_araddr", bus.ARADDR, 64'h8000_0008);
      checkOutput("stall_rdata_valid", 64'(rdata_valid), 64'd0);
      pc = pc + 64'h8;
      jump_en = (i == 1);
      #1;
      checkOutput("flush_nop", 64'(flush_nop), 64'(i == 1));
    end
    jump_en = 1'b0;
    applyStimulus(64'h8000_0100, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0);

    @(negedge clk);
    checkOutput("post_stall_rready", 64'(bus.RREADY), 64'd1);
    checkOutput("mm_rdata_hold", mm_rdata, RD2);

    // Asynchronous reset while in F_R.
    #2 rstn = 1'b1;
    #1;
    checkResetValues("async_rst");
    pc = 64'h8000_0200;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("rearm_arvalid", 64'(bus.ARVALID), 64'd1);
    checkOutput("rearm_araddr", bus.ARADDR, 64'h8000_0200);
    checkOutput("rearm_arid", 64'(bus.ARID), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_bridge.md
AXI_READ_BRIDGE -- requirements
Module: axi_read_bridge

Interface
REQ-001 One clock, clk; reset is rstn, asynchronous and active-high (asserted when rstn=1); all state is clocked on the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rstn  in  1  asynchronous active-high reset.
REQ-004 pc  in  64  instruction fetch address.
REQ-005 instr  out  32  fetched instruction.
REQ-006 instr_valid  out  1  one-cycle pulse when instr is updated.
REQ-007 mm_addr  in  64  load address; mm_ren  in  1  load request level.
REQ-008 mm_rdata  out  64  load data; rdata_valid  out  1  one-cycle pulse when mm_rdata is updated.
REQ-009 jump_en  in  1  redirect request; flush_nop  out  1  pipeline flush.
REQ-010 AR channel outputs: ARID[3:0], ARADDR[63:0], ARLEN[7:0], ARSIZE[2:0], ARBURST[1:0], ARLOCK, ARCACHE[3:0], ARPORT[2:0] (AXI ARPROT), ARQOS[3:0], ARREGION[3:0], ARVALID; input ARREADY.
REQ-011 R channel inputs: RID[3:0], RDATA[63:0], RRESP[1:0], RLAST, RVALID; output RREADY.

Function
REQ-012 flush_nop SHALL equal jump_en combinationally, with no state.
REQ-013 ARLOCK, ARCACHE, ARQOS and ARREGION SHALL be constant 0; ARLEN SHALL be constant 0 (single beat); ARBURST SHALL be constant 2'b01 (INCR).
REQ-014 States: F_AR (fetch address), F_R (fetch data), D_AR (load address), D_R (load data).
REQ-015 F_AR: ARVALID=1, ARID=0, ARADDR=pc, ARSIZE=3'b010, ARPORT=3'b100; on ARVALID&&ARREADY go to F_R.
REQ-016 D_AR: ARVALID=1, ARID=1, ARADDR=mm_addr, ARSIZE=3'b011, ARPORT=3'b000; on ARVALID&&ARREADY go to D_R.
REQ-017 While ARVALID=1 and ARREADY=0, ARADDR, ARID, ARSIZE and ARPORT SHALL be held stable; ARADDR is latched on entry to the AR state.
REQ-018 RREADY SHALL be 1 only in F_R and D_R.
REQ-019 F_R, on RVALID&&RREADY: register instr = pc_latched[2] ? RDATA[63:32] : RDATA[31:0]; pulse instr_valid for exactly the next cycle; go to D_AR if mm_ren=1 in that handshake cycle, else to F_AR.
REQ-020 D_R, on RVALID&&RREADY: register mm_rdata = RDATA; pulse rdata_valid for exactly the next cycle; go to F_AR.
REQ-021 Minimum fetch latency: instr_valid rises 1 cycle after the R handshake, so a zero-wait slave gives 3 cycles from F_AR entry.
REQ-022 RRESP, RID and RLAST SHALL NOT alter sequencing; data is accepted on every R handshake regardless of their values.
REQ-023 instr_valid and rdata_valid SHALL never be 1 in the same cycle; each is 0 except in its pulse cycle.
REQ-024 instr and mm_rdata SHALL hold their last value between pulses.
REQ-025 jump_en has no effect on the bus state machine; an outstanding transaction always completes.
REQ-026 A change of mm_ren outside the F_R handshake cycle SHALL be ignored.

Reset
REQ-027 While rstn=1: state=F_AR-pending (ARVALID=0), instr=0, mm_rdata=0, instr_valid=0, rdata_valid=0, RREADY=0, ARADDR=0, ARID=0.
REQ-028 The first cycle after rstn deasserts SHALL enter F_AR with ARADDR=pc.
REQ-029 Reset asserted mid-transaction SHALL abort immediately to the reset values; the next transaction is a fresh fetch.

Verification
REQ-030 Reset release with pc=0x80000000, ARREADY=1, RVALID=1 on the next cycle with RDATA=0x00000013_00100073 -> ARADDR=0x80000000, ARID=0, ARSIZE=2; instr=0x00100073; one instr_valid pulse.
REQ-031 pc=0x80000004 with the same RDATA -> instr=0x00000013.
REQ-032 mm_ren=1 at the fetch R handshake, mm_addr=0x80001000, RDATA=0x1122334455667788 -> D_AR with ARID=1, ARSIZE=3, ARPORT=0; mm_rdata=0x1122334455667788; one rdata_valid pulse, not coincident with instr_valid; then the next access is a fetch.
REQ-033 ARREADY held 0 for 5 cycles while pc changes -> ARVALID stays 1 and ARADDR stays at the originally latched value until the handshake.
REQ-034 jump_en toggled 0->1->0 -> flush_nop follows in the same cycle; FSM state unaffected.
REQ-035 rstn asserted while in F_R -> all outputs return to reset values asynchronously; after release, a new fetch issues at the current pc.
